// File: rtl/izh_neuron_ctrl.sv
// izh_neuron_ctrl
//   Configures and sequences one izh_neuron_lite instance.
//   - Byte-serial config frame (HEADER, A, B, C, D, CHK with CHK = A^B^C^D)
//     over a valid/ready handshake; param_a..d commit atomically on a good CHK.
//   - Enable tick to the neuron every TICK_DIV clk cycles while run is high
//     and a parameter set has been committed.
//   - Spike count over WINDOW ticks, reported as a saturating spike_rate.
//
// Ports
//   clk           in   clock, all logic on posedge
//   reset         in   synchronous, active-high
//   cfg_valid     in   cfg_data valid
//   cfg_data      in   [7:0] config byte
//   cfg_ready     out  byte accepted when cfg_valid && cfg_ready (low only in COMMIT)
//   cfg_err       out  1-cycle pulse: checksum mismatch or inter-byte timeout
//   run           in   level, tick generator running
//   spike_in      in   neuron spike_out
//   param_a..d    out  [7:0] committed neuron parameters
//   params_ready  out  1 once any frame has committed
//   enable        out  1-cycle tick pulse to the neuron
//   spike_rate    out  [CNT_W-1:0] spikes in last completed window, saturating
//   rate_valid    out  1-cycle pulse coincident with a new spike_rate value
module izh_neuron_ctrl #(
  parameter int unsigned TICK_DIV = 16,
  parameter int unsigned WINDOW   = 64,
  parameter int unsigned CNT_W    = 8,
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [7:0]       cfg_data,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             run,
  input  logic             spike_in,
  output logic [7:0]       param_a,
  output logic [7:0]       param_b,
  output logic [7:0]       param_c,
  output logic [7:0]       param_d,
  output logic             params_ready,
  output logic             enable,
  output logic [CNT_W-1:0] spike_rate,
  output logic             rate_valid
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_COMMIT
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       byte_idx;
  logic [3:0][7:0]  shadow;
  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       chk_xor;
  logic             accept;
  logic             load_byte;
  logic             chk_good;
  logic             chk_bad;
  logic             timed_out;

  logic [TICK_W-1:0] tick_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  spk_cnt;
  logic [CNT_W-1:0]  spk_inc;
  logic              win_done;
  logic              counting;

  // ---------------------------------------------------------------------------
  // Frame FSM: next state and handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg_ready = (state != S_COMMIT);
    accept    = cfg_valid && cfg_ready;
    chk_xor   = shadow[0] ^ shadow[1] ^ shadow[2] ^ shadow[3];
    load_byte = 1'b0;
    chk_good  = 1'b0;
    chk_bad   = 1'b0;
    timed_out = 1'b0;
    state_nxt = state;

    case (state)
      S_IDLE: begin
        if (accept && (cfg_data == HEADER)) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          load_byte = 1'b1;
          if (byte_idx == 2'd3) begin
            state_nxt = S_CHECK;
          end
        end else if (to_cnt == TO_LAST) begin
          timed_out = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (cfg_data == chk_xor) begin
            chk_good  = 1'b1;
            state_nxt = S_COMMIT;
          end else begin
            chk_bad   = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (to_cnt == TO_LAST) begin
          timed_out = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_COMMIT: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame datapath: shadows, timeout, committed parameters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx     <= '0;
      shadow       <= '0;
      to_cnt       <= '0;
      param_a      <= '0;
      param_b      <= '0;
      param_c      <= '0;
      param_d      <= '0;
      params_ready <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err <= chk_bad || timed_out;

      if ((state == S_LOAD) || (state == S_CHECK)) begin
        to_cnt <= accept ? '0 : to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end

      if (state == S_IDLE) begin
        byte_idx <= '0;
      end else if (load_byte) begin
        shadow[byte_idx] <= cfg_data;
        byte_idx         <= byte_idx + 2'd1;
      end

      if (chk_good) begin
        param_a      <= shadow[0];
        param_b      <= shadow[1];
        param_c      <= shadow[2];
        param_d      <= shadow[3];
        params_ready <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tick generator and spike-rate window
  // ---------------------------------------------------------------------------
  always_comb begin
    counting = run && params_ready;
    enable   = counting && (tick_cnt == TICK_LAST) && (state != S_COMMIT);
    spk_inc  = (spike_in && (spk_cnt != '1)) ? spk_cnt + CNT_W'(1) : spk_cnt;
  end

  // win_done marks the cycle after the final tick of a window, so the spike
  // the neuron registers in response to that tick is still counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt   <= '0;
      win_cnt    <= '0;
      spk_cnt    <= '0;
      win_done   <= 1'b0;
      spike_rate <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (state == S_COMMIT) begin
        tick_cnt <= '0;
        win_cnt  <= '0;
        spk_cnt  <= '0;
        win_done <= 1'b0;
      end else begin
        if (!counting || (tick_cnt == TICK_LAST)) begin
          tick_cnt <= '0;
        end else begin
          tick_cnt <= tick_cnt + TICK_W'(1);
        end

        if (win_done) begin
          spike_rate <= spk_inc;
          rate_valid <= 1'b1;
          spk_cnt    <= '0;
        end else begin
          spk_cnt <= spk_inc;
        end

        win_done <= enable && (win_cnt == WIN_LAST);
        if (enable) begin
          win_cnt <= (win_cnt == WIN_LAST) ? '0 : win_cnt + WIN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_izh_neuron_ctrl.sv
module tb_izh_neuron_ctrl;

  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_valid;
  logic [7:0]       cfg_data;
  logic             cfg_ready;
  logic             cfg_err;
  logic             run;
  logic             spike_in;
  logic [7:0]       param_a;
  logic [7:0]       param_b;
  logic [7:0]       param_c;
  logic [7:0]       param_d;
  logic             params_ready;
  logic             enable;
  logic [CNT_W-1:0] spike_rate;
  logic             rate_valid;

  int checks   = 0;
  int failures = 0;
  int n_en     = 0;
  int n_err    = 0;
  int n_rv     = 0;
  logic [CNT_W-1:0] last_rate = '0;

  always #5 clk = ~clk;

  izh_neuron_ctrl #(
    .TICK_DIV (4),
    .WINDOW   (4),
    .CNT_W    (CNT_W),
    .HEADER   (8'hA5),
    .TIMEOUT  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .run          (run),
    .spike_in     (spike_in),
    .param_a      (param_a),
    .param_b      (param_b),
    .param_c      (param_c),
    .param_d      (param_d),
    .params_ready (params_ready),
    .enable       (enable),
    .spike_rate   (spike_rate),
    .rate_valid   (rate_valid)
  );

  // Advance one clock and sample the new cycle's outputs 1 ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (enable)     n_en++;
    if (cfg_err)    n_err++;
    if (rate_valid) begin
      n_rv++;
      last_rate = spike_rate;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    cfg_valid = 1'b1;
    cfg_data  = b;
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(b);
    send_byte(c);
    send_byte(d);
    send_byte(chk);
  endtask

  initial begin
    int n0;
    int rv0;
    int err0;
    int first;
    int last;
    int gap_min;
    int gap_max;
    int en4_i;
    int rv_i;
    int en_at_rv;
    logic en_prev;

    // 1: reset held 3 cycles with a HEADER byte offered
    reset     = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 8'hA5;
    run       = 1'b0;
    spike_in  = 1'b0;
    repeat (3) cycle();
    check("rst_param_a", 32'(param_a), 32'h00);
    check("rst_param_b", 32'(param_b), 32'h00);
    check("rst_param_c", 32'(param_c), 32'h00);
    check("rst_param_d", 32'(param_d), 32'h00);
    check("rst_params_ready", 32'(params_ready), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_rate_valid", 32'(rate_valid), 32'd0);
    check("rst_spike_rate", 32'(spike_rate), 32'd0);
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cycle();
    check("rst_pulses", 32'(n_err + n_rv + n_en), 32'd0);

    // 2: good frame back-to-back
    send_frame(8'h02, 8'h14, 8'h00, 8'h08, 8'h1E);
    check("good_param_a", 32'(param_a), 32'h02);
    check("good_param_b", 32'(param_b), 32'h14);
    check("good_param_c", 32'(param_c), 32'h00);
    check("good_param_d", 32'(param_d), 32'h08);
    check("good_params_ready", 32'(params_ready), 32'd1);
    check("commit_cfg_ready_low", 32'(cfg_ready), 32'd0);
    cycle();
    check("after_commit_cfg_ready", 32'(cfg_ready), 32'd1);
    repeat (3) cycle();
    check("good_no_err", 32'(n_err), 32'd0);

    // 3: bad checksum, then a normal frame
    send_frame(8'h02, 8'h14, 8'h00, 8'h08, 8'h1F);
    check("badchk_err_pulse", 32'(cfg_err), 32'd1);
    check("badchk_param_a", 32'(param_a), 32'h02);
    check("badchk_param_d", 32'(param_d), 32'h08);
    cycle();
    check("badchk_err_drop", 32'(cfg_err), 32'd0);
    check("badchk_err_count", 32'(n_err), 32'd1);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
    check("reload_param_a", 32'(param_a), 32'h11);
    check("reload_param_b", 32'(param_b), 32'h22);
    check("reload_param_c", 32'(param_c), 32'h33);
    check("reload_param_d", 32'(param_d), 32'h44);
    cycle();

    // 4: inter-byte timeout, trailing bytes dropped in IDLE
    send_byte(8'hA5);
    send_byte(8'h02);
    repeat (7) cycle();
    check("timeout_not_yet", 32'(cfg_err), 32'd0);
    cycle();
    check("timeout_err_pulse", 32'(cfg_err), 32'd1);
    send_byte(8'h14);
    send_byte(8'h00);
    send_byte(8'h08);
    send_byte(8'h1E);
    repeat (10) cycle();
    check("timeout_err_count", 32'(n_err), 32'd2);
    check("timeout_param_a", 32'(param_a), 32'h11);
    check("timeout_param_d", 32'(param_d), 32'h44);

    // 5: tick generator
    n0 = n_en;
    repeat (10) cycle();
    check("run0_no_enable", 32'(n_en - n0), 32'd0);

    n0      = n_en;
    rv0     = n_rv;
    first   = -1;
    last    = -1;
    gap_min = 1000;
    gap_max = 0;
    run     = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (enable) begin
        if (last >= 0) begin
          if (i - last < gap_min) gap_min = i - last;
          if (i - last > gap_max) gap_max = i - last;
        end
        if (first < 0) first = i;
        last = i;
      end
    end
    run = 1'b0;
    check("tick_count", 32'(n_en - n0), 32'd5);
    check("tick_first", 32'(first), 32'd3);
    check("tick_gap_min", 32'(gap_min), 32'd4);
    check("tick_gap_max", 32'(gap_max), 32'd4);
    check("idle_window_rv", 32'(n_rv - rv0), 32'd1);
    check("idle_window_rate", 32'(last_rate), 32'd0);

    n0 = n_en;
    repeat (12) cycle();
    check("run_fall_no_enable", 32'(n_en - n0), 32'd0);

    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    check("noparams_ready", 32'(params_ready), 32'd0);
    run = 1'b1;
    n0  = n_en;
    repeat (12) cycle();
    check("noparams_no_enable", 32'(n_en - n0), 32'd0);
    run = 1'b0;

    // 6: spike rate with one spike after every tick (saturates at 3)
    send_frame(8'h02, 8'h14, 8'h00, 8'h08, 8'h1E);
    cycle();
    n0       = n_en;
    rv0      = n_rv;
    en4_i    = -1;
    rv_i     = -1;
    en_at_rv = -1;
    en_prev  = 1'b0;
    run      = 1'b1;
    for (int i = 1; i <= 40 && rv_i < 0; i++) begin
      cycle();
      spike_in = en_prev;
      en_prev  = enable;
      if (enable && (n_en - n0 == 4)) en4_i = i;
      if (rate_valid) begin
        rv_i     = i;
        en_at_rv = n_en - n0;
      end
    end
    spike_in = 1'b0;
    check("rate_found", 32'(rv_i >= 0), 32'd1);
    check("rate_enables_in_window", 32'(en_at_rv), 32'd4);
    check("rate_saturated", 32'(last_rate), 32'd3);
    check("rate_valid_after_4th", 32'((rv_i - en4_i >= 1) && (rv_i - en4_i <= 2)), 32'd1);

    n0       = n_en;
    rv_i     = -1;
    en_at_rv = -1;
    for (int i = 1; i <= 40 && rv_i < 0; i++) begin
      cycle();
      if (rate_valid) begin
        rv_i     = i;
        en_at_rv = n_en - n0;
      end
    end
    check("rate0_found", 32'(rv_i >= 0), 32'd1);
    check("rate0_enables", 32'(en_at_rv), 32'd4);
    check("rate0_value", 32'(last_rate), 32'd0);
    check("rate0_pulses", 32'(n_rv - rv0), 32'd2);

    // 7: reset mid-frame and mid-window
    send_byte(8'hA5);
    send_byte(8'h02);
    rv0   = n_rv;
    err0  = n_err;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    run   = 1'b0;
    repeat (15) cycle();
    check("midrst_no_err", 32'(n_err - err0), 32'd0);
    check("midrst_no_rv", 32'(n_rv - rv0), 32'd0);
    check("midrst_params_ready", 32'(params_ready), 32'd0);
    check("midrst_param_a", 32'(param_a), 32'h00);
    check("midrst_spike_rate", 32'(spike_rate), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
